alu_datapath: RTL and testbench
===============================

Name: alu_datapath

Overview:
- Multi-cycle ALU execution unit that sits directly under the ALU control FSM.
- Consumes the control FSM's encoded state (00 idle, 01 calc, 10 fin) and returns the done_in handshake to it.
- Computes add/sub/logic ops in one cycle, and unsigned multiply (shift-add) and divide (restoring) iteratively, one bit per cycle.

Parameters:
- WIDTH, 8, operand width; result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset_a  input  1  asynchronous, active-low reset (asserted when 0).
- state_in  input  2  control state: 00 idle, 01 calc, 10 fin, 11 treated as fin.
- opcode  input  3  operation select, sampled at launch.
- op_a  input  WIDTH  operand A, sampled at launch.
- op_b  input  WIDTH  operand B, sampled at launch.
- result  output  2*WIDTH  registered result.
- done  output  1  level, result valid; drives the control FSM's done_in.
- busy  output  1  iteration in progress.
- zero  output  1  result == 0, registered with result.
- div_by_zero  output  1  last DIV had op_b == 0.

Behaviour:
- Reset (reset_a=0, async): FSM goes to IDLE; result=0, done=0, busy=0, zero=0, div_by_zero=0; iteration counter and internal registers are cleared.
- Internal FSM states: IDLE, RUN, DONE.
- IDLE:
  - Launch = rising edge with state_in==01.
  - At launch: latch opcode, op_a and op_b; clear div_by_zero.
  - Single-cycle ops: write result and go to DONE.
  - MUL/DIV with a nonzero divisor: go to RUN, counter=0, busy=1.
  - Any other state_in: stay in IDLE.
- RUN:
  - One iteration per edge; counter increments.
  - On the edge where counter==WIDTH-1: write result, busy=0, go to DONE.
  - state_in==00 sampled (abort): go to IDLE, busy=0; partial result discarded; result, zero and div_by_zero keep prior values.
- DONE:
  - done=1, held until an edge samples state_in==00; that edge returns to IDLE with done=0.
  - state_in 01, 10 and 11 all hold DONE.
  - result is stable throughout DONE.
- Latency, counting edge L as launch:
  - Single-cycle ops: done=1 after edge L.
  - MUL/DIV: done=1 after edge L+WIDTH.
- Opcodes and result formats:
  - 000 ADD: {zeros, carry, a+b}; carry at bit WIDTH.
  - 001 SUB: {zeros, borrow, a-b}; borrow=1 when a<b.
  - 010 AND, 011 OR, 100 XOR: zero-extended.
  - 101 MUL: full unsigned 2*WIDTH product. Shift-add: multiplier LSB tested each cycle; accumulator (WIDTH+1 bits) and multiplier shift right together.
  - 110 DIV: {remainder, quotient}, unsigned restoring division. Each cycle shift {rem, quo} left 1, trial-subtract op_b, set the quotient bit if no borrow.
  - 110 DIV with op_b==0: single-cycle; quotient=all ones, remainder=op_a, div_by_zero=1.
  - 111 reserved: single-cycle, result=0.
- zero is updated only when result is written.
- Opcode and operand changes after launch have no effect until the next launch.
- Back-to-back operations require state_in to pass through 00, which the control FSM guarantees.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined: adds output port ovf (1 bit), registered with result.
  - Set on signed two's-complement overflow for ADD and SUB.
  - 0 for all other ops.
  - Reset value 0; holds its value on abort.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- ADD 200+100, state_in 00→01 → done high after launch edge; result=16'h012C; zero=0.
- SUB 5-7 → result=16'h01FE (borrow=1, low byte 0xFE); with ALU_OVF_EN: ovf=0. ADD 127+1 → ovf=1.
- MUL 255*255 → busy high 8 cycles; done after edge L+8; result=16'hFE01. MUL 0*77 → result 0, zero=1.
- DIV 100/7 → result=16'h020E after L+8. DIV 5/0 → result=16'h05FF, div_by_zero=1, done after edge L.
- Abort: launch MUL 3*3 with prior result 16'h012C; drive state_in=00 after 4 RUN edges → done stays 0, busy drops, result stays 16'h012C; relaunch → result 16'h0009.
- Reset: pull reset_a low mid-DIV → result, done and busy go 0 immediately without a clock edge; after release, FSM is in IDLE and a new launch completes normally.

Source files
------------

// File: rtl/alu_datapath.sv
// alu_datapath: multi-cycle ALU execution unit driven by the ALU control FSM.
// Single-cycle add/sub/logic; iterative shift-add multiply and restoring
// divide, one bit per clock. Define ALU_OVF_EN to add the signed-overflow
// output ovf for ADD/SUB.
module alu_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic [1:0]         state_in,
  input  logic [2:0]         opcode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               zero,
`ifdef ALU_OVF_EN
  output logic               ovf,
`endif
  output logic               div_by_zero
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  localparam logic [1:0] CTL_IDLE = 2'b00;
  localparam logic [1:0] CTL_CALC = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] hi_q;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier shifting out / quotient shifting in
  logic             ovf_q;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   dif_c;
  logic [RES_W-1:0] alu_res_c;
  logic             alu_ovf_c;
  logic             multi_c;
  logic [WIDTH:0]   mul_p_c;
  logic [WIDTH:0]   div_sh_c;
  logic [WIDTH:0]   div_df_c;
  logic [WIDTH-1:0] hi_n_c;
  logic [WIDTH-1:0] lo_n_c;

  // Single-cycle result and one iteration step of the multiply/divide datapath
  always_comb begin
    sum_c     = {1'b0, op_a} + {1'b0, op_b};
    dif_c     = {1'b0, op_a} - {1'b0, op_b};
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    multi_c   = (opcode == OP_MUL) || ((opcode == OP_DIV) && (op_b != '0));
    case (opcode)
      OP_ADD: begin
        alu_res_c = {{(WIDTH-1){1'b0}}, sum_c};
        alu_ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_c[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = {{(WIDTH-1){1'b0}}, dif_c};
        alu_ovf_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif_c[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res_c = {{WIDTH{1'b0}}, op_a & op_b};
      OP_OR:   alu_res_c = {{WIDTH{1'b0}}, op_a | op_b};
      OP_XOR:  alu_res_c = {{WIDTH{1'b0}}, op_a ^ op_b};
      OP_DIV:  alu_res_c = {op_a, {WIDTH{1'b1}}};   // only reached with op_b == 0
      default: alu_res_c = '0;
    endcase

    mul_p_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    div_sh_c = {hi_q, lo_q[WIDTH-1]};
    div_df_c = div_sh_c - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_df_c[WIDTH]) begin
        hi_n_c = div_df_c[WIDTH-1:0];
        lo_n_c = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n_c = div_sh_c[WIDTH-1:0];
        lo_n_c = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n_c = mul_p_c[WIDTH:1];
      lo_n_c = {mul_p_c[0], lo_q[WIDTH-1:1]};
    end
  end

  // Control FSM with registered result and status outputs
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_in == CTL_CALC) begin
            div_by_zero <= 1'b0;
            is_div_q    <= (opcode == OP_DIV);
            opnd_q      <= (opcode == OP_MUL) ? op_a : op_b;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= (opcode == OP_MUL) ? op_b : op_a;
            if (multi_c) begin
              busy    <= 1'b1;
              state_q <= S_RUN;
            end else begin
              result      <= alu_res_c;
              zero        <= (alu_res_c == '0);
              ovf_q       <= alu_ovf_c;
              div_by_zero <= (opcode == OP_DIV);
              done        <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (state_in == CTL_IDLE) begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hi_q  <= hi_n_c;
            lo_q  <= lo_n_c;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result  <= {hi_n_c, lo_n_c};
              zero    <= ({hi_n_c, lo_n_c} == '0);
              ovf_q   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (state_in == CTL_IDLE) begin
            done    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath (WIDTH=8).
module tb_alu_datapath;

  logic        clk;
  logic        reset_a;
  logic [1:0]  state_in;
  logic [2:0]  opcode;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        zero;
  logic        div_by_zero;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  alu_datapath #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .state_in    (state_in),
    .opcode      (opcode),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (result),
    .done        (done),
    .busy        (busy),
    .zero        (zero),
`ifdef ALU_OVF_EN
    .ovf         (ovf),
`endif
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op with state_in=01 and apply the launch edge
  task automatic launch(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    opcode   = op;
    op_a     = a;
    op_b     = b;
    state_in = 2'b01;
    tick();
  endtask

  task automatic to_idle();
    state_in = 2'b00;
    tick();
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    reset_a  = 1'b0;
    state_in = 2'b00;
    opcode   = 3'b000;
    op_a     = 8'd0;
    op_b     = 8'd0;
    #12;
    check("rst_result", 32'(result), 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset_a = 1'b1;
    tick();
    check("idle_hold", 32'(done), 32'd0);

    // ADD 200+100
    launch(3'b000, 8'd200, 8'd100);
    check("add_done", 32'(done), 32'd1);
    check("add_result", 32'(result), 32'h012C);
    check("add_zero", 32'(zero), 32'd0);
    check("add_busy", 32'(busy), 32'd0);
    state_in = 2'b10;
    op_a     = 8'd0;
    tick();
    check("add_fin_done", 32'(done), 32'd1);
    check("add_fin_result", 32'(result), 32'h012C);
    state_in = 2'b11;
    tick();
    check("add_st11_done", 32'(done), 32'd1);
    to_idle();

    // SUB 5-7
    launch(3'b001, 8'd5, 8'd7);
    check("sub_result", 32'(result), 32'h01FE);
`ifdef ALU_OVF_EN
    check("sub_ovf", 32'(ovf), 32'd0);
`endif
    to_idle();

    // ADD 127+1 signed overflow
    launch(3'b000, 8'd127, 8'd1);
    check("add_ovf_result", 32'(result), 32'h0080);
`ifdef ALU_OVF_EN
    check("add_ovf", 32'(ovf), 32'd1);
`endif
    to_idle();

    // Logic ops and reserved
    launch(3'b010, 8'hF0, 8'h3C);
    check("and_result", 32'(result), 32'h0030);
    to_idle();
    launch(3'b011, 8'hF0, 8'h3C);
    check("or_result", 32'(result), 32'h00FC);
    to_idle();
    launch(3'b100, 8'hF0, 8'h3C);
    check("xor_result", 32'(result), 32'h00CC);
    to_idle();
    launch(3'b111, 8'hF0, 8'h3C);
    check("rsv_done", 32'(done), 32'd1);
    check("rsv_result", 32'(result), 32'h0);
    check("rsv_zero", 32'(zero), 32'd1);
    to_idle();

    // MUL 255*255, done after L+8
    launch(3'b101, 8'd255, 8'd255);
    check("mul_busy_l", 32'(busy), 32'd1);
    check("mul_done_l", 32'(done), 32'd0);
    op_a = 8'd1;
    op_b = 8'd1;
    for (int i = 1; i <= 7; i++) tick();
    check("mul_busy_l7", 32'(busy), 32'd1);
    check("mul_done_l7", 32'(done), 32'd0);
    tick();
    check("mul_done_l8", 32'(done), 32'd1);
    check("mul_busy_l8", 32'(busy), 32'd0);
    check("mul_result", 32'(result), 32'hFE01);
    check("mul_zero", 32'(zero), 32'd0);
`ifdef ALU_OVF_EN
    check("mul_ovf", 32'(ovf), 32'd0);
`endif
    to_idle();

    // MUL 0*77
    launch(3'b101, 8'd0, 8'd77);
    for (int i = 1; i <= 8; i++) tick();
    check("mul0_result", 32'(result), 32'h0);
    check("mul0_zero", 32'(zero), 32'd1);
    to_idle();

    // DIV 5/0: single-cycle
    launch(3'b110, 8'd5, 8'd0);
    check("dz_done", 32'(done), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_result", 32'(result), 32'h05FF);
    check("dz_flag", 32'(div_by_zero), 32'd1);
    to_idle();

    // DIV 100/7 = 14 r 2
    launch(3'b110, 8'd100, 8'd7);
    check("div_flag_clr", 32'(div_by_zero), 32'd0);
    for (int i = 1; i <= 7; i++) tick();
    check("div_done_l7", 32'(done), 32'd0);
    tick();
    check("div_done_l8", 32'(done), 32'd1);
    check("div_result", 32'(result), 32'h020E);
    to_idle();

    // Abort MUL 3*3 with prior result 0x012C
    launch(3'b000, 8'd200, 8'd100);
    check("pre_abort_result", 32'(result), 32'h012C);
    to_idle();
    launch(3'b101, 8'd3, 8'd3);
    for (int i = 1; i <= 4; i++) tick();
    state_in = 2'b00;
    tick();
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'h012C);
    check("abort_zero", 32'(zero), 32'd0);
    for (int i = 1; i <= 6; i++) tick();
    check("abort_stay_idle", 32'(done), 32'd0);
    launch(3'b101, 8'd3, 8'd3);
    for (int i = 1; i <= 8; i++) tick();
    check("relaunch_done", 32'(done), 32'd1);
    check("relaunch_result", 32'(result), 32'h0009);
    to_idle();

    // Asynchronous reset mid-DIV
    launch(3'b110, 8'd100, 8'd7);
    for (int i = 1; i <= 3; i++) tick();
    #2;
    reset_a = 1'b0;
    #1;
    check("arst_result", 32'(result), 32'h0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    state_in = 2'b00;
    reset_a  = 1'b1;
    tick();
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    launch(3'b000, 8'd1, 8'd2);
    check("post_rst_add_done", 32'(done), 32'd1);
    check("post_rst_add", 32'(result), 32'h0003);
    to_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
